// File: rtl/vic64_flash_pkg.sv
// Shared definitions for the flash loader and the SPI flash controller:
// address widths and the state encodings of both state machines, so that
// benches and debug logic can decode either one.
package vic64_flash_pkg;

    localparam int FLASH_ADDR_W = 24;

    // Bulk-copy loader states
    typedef enum logic [2:0] {
        LD_IDLE      = 3'd0,
        LD_REQ_ADDR  = 3'd1,
        LD_WAIT_LOW  = 3'd2,
        LD_WAIT_BYTE = 3'd3,
        LD_WRITE     = 3'd4,
        LD_FINISH    = 3'd5
    } loader_state_e;

    // SPI flash controller states
    typedef enum logic [2:0] {
        FC_IDLE  = 3'd0,
        FC_CMD   = 3'd1,
        FC_ADDR  = 3'd2,
        FC_DUMMY = 3'd3,
        FC_DATA  = 3'd4,
        FC_HOLD  = 3'd5
    } flash_ctrl_state_e;

endpackage

// File: rtl/flash_loader.sv
// Bulk-copy sequencer: drives the flash controller read port and writes
// each delivered byte into on-chip RAM at consecutive (wrapping) addresses.
//
// Handshake with the flash controller: request_read_addr / request_read_next
// are single-cycle pulses; d_ready is a level that stays high after a byte
// is delivered until the next request is seen. A byte is taken only after
// d_ready has been observed low following a request (WAIT_LOW), so each
// low-to-high cycle of d_ready yields exactly one RAM write.
module flash_loader
    import vic64_flash_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [FLASH_ADDR_W-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [ADDR_WIDTH:0]     length,
    output logic                    busy,
    output logic                    done,
    output logic [FLASH_ADDR_W-1:0] flash_addr,
    output logic                    request_read_addr,
    output logic                    request_read_next,
    input  logic                    d_ready,
    input  logic [7:0]              d_out,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [7:0]              ram_wdata,
    output loader_state_e           dbg_state
);

    loader_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [FLASH_ADDR_W-1:0] src_q, src_d;
    logic [7:0]              wdata_q, wdata_d;

    logic last_byte;
    assign last_byte = (remaining_q == (ADDR_WIDTH+1)'(1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LD_IDLE;
            remaining_q <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dst_d       = dst_q;
        src_d       = src_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            LD_IDLE: begin
                if (start) begin
                    src_d       = src_addr;
                    dst_d       = dst_addr;
                    remaining_d = length;
                    state_d     = (length == '0) ? LD_FINISH : LD_REQ_ADDR;
                end
            end
            LD_REQ_ADDR: state_d = LD_WAIT_LOW;
            LD_WAIT_LOW: begin
                // Discard the level left high by the previous byte
                if (!d_ready) state_d = LD_WAIT_BYTE;
            end
            LD_WAIT_BYTE: begin
                if (d_ready) begin
                    wdata_d = d_out;
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                dst_d       = dst_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                state_d     = last_byte ? LD_FINISH : LD_WAIT_LOW;
            end
            LD_FINISH: state_d = LD_IDLE;
            default:   state_d = LD_IDLE;
        endcase
    end

    // Outputs decode directly from the registered state, so each pulse lasts
    // exactly one state-cycle and all outputs are zero in reset.
    assign busy              = (state_q != LD_IDLE) && (state_q != LD_FINISH);
    assign done              = (state_q == LD_FINISH);
    assign request_read_addr = (state_q == LD_REQ_ADDR);
    assign ram_we            = (state_q == LD_WRITE);
    assign request_read_next = (state_q == LD_WRITE) && !last_byte;
    assign flash_addr        = src_q;
    assign ram_addr          = dst_q;
    assign ram_wdata         = wdata_q;
    assign dbg_state         = state_q;

endmodule
